// File: rtl/periph_bus_arbiter.sv
// -----------------------------------------------------------------------------
// periph_bus_arbiter
//
// Two-master arbiter for the shared 8-bit peripheral bus. Master 0 is the
// processor core, master 1 a secondary master (debug loader / DMA). One
// single-cycle transfer is granted per clock. Accepted writes appear on the
// registered OUTBUS controls, accepted reads on the registered INBUS controls,
// and read data returned on inbus_data is routed back to the issuing master.
//
// Optional feature macro: PERIPH_BUS_ARB_LOCK_EN
//   When defined, m0_lock / m1_lock exist and the master of the most recent
//   accepted transfer can hold the bus against the other master.
//
// Parameters
//   ADDR_W      peripheral address width
//   DATA_W      data width
//   FIXED_PRIO  0 = round-robin on ties, 1 = master 0 always wins ties
//
// Ports
//   clk                  single clock
//   reset                synchronous, active-low
//   mX_req/we/addr/wdata master request, direction, address, write data
//   mX_lock              bus lock request (lock build only)
//   mX_gnt               combinational grant, transfer accepted on req & gnt
//   mX_rdata/rvalid      read return, rdata is zero while rvalid is low
//   outbus_addr/data/we  registered write path to the peripherals
//   inbus_addr/re        registered read path to the peripherals
//   inbus_data           OR of peripheral read data, valid the cycle after re
// -----------------------------------------------------------------------------
module periph_bus_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
`ifdef PERIPH_BUS_ARB_LOCK_EN
   input  logic              m0_lock,
   input  logic              m1_lock,
`endif
   output logic              m0_gnt,
   output logic              m1_gnt,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m0_rvalid,
   output logic              m1_rvalid,
   output logic [ADDR_W-1:0] outbus_addr,
   output logic [DATA_W-1:0] outbus_data,
   output logic              outbus_we,
   output logic [ADDR_W-1:0] inbus_addr,
   output logic              inbus_re,
   input  logic [DATA_W-1:0] inbus_data
);

   // Master of the most recent accepted transfer (0 = m0, 1 = m1).
   logic              last_r;
   // Read tag stage 1: a read is on the INBUS this cycle, and who owns it.
   logic              tag_vld_r;
   logic              tag_own_r;

   logic              blk0_s;
   logic              blk1_s;
   logic              cand0_s;
   logic              cand1_s;
   logic              gnt0_s;
   logic              gnt1_s;
   logic              acc_s;
   logic              sel_we_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;

`ifdef PERIPH_BUS_ARB_LOCK_EN
   // Lock is armed while the last transfer's master keeps its lock high.
   logic              lock_hold_r;
   logic              last_lock_s;

   // Lock level of the master that performed the last accepted transfer.
   always_comb begin
      last_lock_s = 1'b0;
      if (last_r) begin
         last_lock_s = m1_lock;
      end else begin
         last_lock_s = m0_lock;
      end
   end
`endif

   // Grant decision: lock blocking, then single-requester / tie-break rules.
   always_comb begin
      blk0_s = 1'b0;
      blk1_s = 1'b0;
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
`ifdef PERIPH_BUS_ARB_LOCK_EN
      // The combinational lock term makes release take effect in the very
      // cycle the holder drops its lock.
      if (lock_hold_r && last_lock_s) begin
         if (last_r) begin
            blk0_s = 1'b1;
         end else begin
            blk1_s = 1'b1;
         end
      end else begin
         blk0_s = 1'b0;
         blk1_s = 1'b0;
      end
`endif
      // Reset low suppresses any grant so a same-cycle request is not accepted.
      cand0_s = m0_req & ~blk0_s & reset;
      cand1_s = m1_req & ~blk1_s & reset;
      if (cand0_s && cand1_s) begin
         if (FIXED_PRIO != 32'sd0) begin
            gnt0_s = 1'b1;
         end else if (last_r) begin
            gnt0_s = 1'b1;
         end else begin
            gnt1_s = 1'b1;
         end
      end else begin
         gnt0_s = cand0_s;
         gnt1_s = cand1_s;
      end
   end

   // Select the accepted master's transfer attributes.
   always_comb begin
      acc_s = gnt0_s | gnt1_s;
      if (gnt1_s) begin
         sel_we_s    = m1_we;
         sel_addr_s  = m1_addr;
         sel_wdata_s = m1_wdata;
      end else begin
         sel_we_s    = m0_we;
         sel_addr_s  = m0_addr;
         sel_wdata_s = m0_wdata;
      end
   end

   assign m0_gnt = gnt0_s;
   assign m1_gnt = gnt1_s;

   // Bus control registers, round-robin pointer and the read tag pipeline.
   always_ff @(posedge clk) begin
      if (!reset) begin
         outbus_we   <= 1'b0;
         outbus_addr <= {ADDR_W{1'b0}};
         outbus_data <= {DATA_W{1'b0}};
         inbus_re    <= 1'b0;
         inbus_addr  <= {ADDR_W{1'b0}};
         last_r      <= 1'b1;
         tag_vld_r   <= 1'b0;
         tag_own_r   <= 1'b0;
         m0_rvalid   <= 1'b0;
         m1_rvalid   <= 1'b0;
      end else begin
         if (acc_s && sel_we_s) begin
            outbus_we   <= 1'b1;
            outbus_addr <= sel_addr_s;
            outbus_data <= sel_wdata_s;
         end else begin
            outbus_we   <= 1'b0;
            outbus_addr <= {ADDR_W{1'b0}};
            outbus_data <= {DATA_W{1'b0}};
         end
         if (acc_s && !sel_we_s) begin
            inbus_re   <= 1'b1;
            inbus_addr <= sel_addr_s;
            tag_vld_r  <= 1'b1;
            tag_own_r  <= gnt1_s;
         end else begin
            inbus_re   <= 1'b0;
            inbus_addr <= {ADDR_W{1'b0}};
            tag_vld_r  <= 1'b0;
            tag_own_r  <= 1'b0;
         end
         // Second tag stage doubles as the per-master read strobe.
         m0_rvalid <= tag_vld_r & ~tag_own_r;
         m1_rvalid <= tag_vld_r & tag_own_r;
         if (acc_s) begin
            last_r <= gnt1_s;
         end else begin
            last_r <= last_r;
         end
      end
   end

`ifdef PERIPH_BUS_ARB_LOCK_EN
   // Lock state: armed by a locked accepted transfer, dropped when lock falls.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lock_hold_r <= 1'b0;
      end else if (acc_s) begin
         lock_hold_r <= gnt1_s ? m1_lock : m0_lock;
      end else if (!last_lock_s) begin
         lock_hold_r <= 1'b0;
      end else begin
         lock_hold_r <= lock_hold_r;
      end
   end
`endif

   // Peripheral data is only forwarded to the master that owns the return.
   assign m0_rdata = m0_rvalid ? inbus_data : {DATA_W{1'b0}};
   assign m1_rdata = m1_rvalid ? inbus_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_periph_bus_arbiter
//
// Two arbiter instances share one stimulus stream: lane 0 is round-robin,
// lane 1 is fixed priority (lock inputs tied low). A reference model inside
// the driver task decides the winner of every cycle from the arbitration
// rules and pushes the expected bus event and read return into per-lane
// queues; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_periph_bus_arbiter;

   typedef struct {
      int         due;
      logic       we;
      logic [7:0] oa;
      logic [7:0] od;
      logic       re;
      logic [7:0] ia;
   } bus_t;

   typedef struct {
      int         due;
      int         own;
      logic [7:0] data;
   } rd_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [7:0] m0_addr = 8'h00, m0_wdata = 8'h00, m1_addr = 8'h00, m1_wdata = 8'h00;
   logic       m0_lock = 1'b0, m1_lock = 1'b0;

   logic [1:0] gnt0_a, gnt1_a, rv0_a, rv1_a, obwe_a, ibre_a;
   logic [7:0] oba_a[2], obd_a[2], iba_a[2], rd0_a[2], rd1_a[2];
   logic [7:0] ibd_a[2];

   logic [7:0] mem[256];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   bit         mon_en = 1'b0;

   int         last_m[2];
   int         lock_owner[2];
   logic [1:0] exp_gnt[2];
   bus_t       bq[2][$];
   rd_t        rq[2][$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   periph_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) u_rr (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef PERIPH_BUS_ARB_LOCK_EN
      .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
      .m0_gnt(gnt0_a[0]), .m1_gnt(gnt1_a[0]),
      .m0_rdata(rd0_a[0]), .m1_rdata(rd1_a[0]),
      .m0_rvalid(rv0_a[0]), .m1_rvalid(rv1_a[0]),
      .outbus_addr(oba_a[0]), .outbus_data(obd_a[0]), .outbus_we(obwe_a[0]),
      .inbus_addr(iba_a[0]), .inbus_re(ibre_a[0]), .inbus_data(ibd_a[0])
   );

   periph_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) u_fp (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef PERIPH_BUS_ARB_LOCK_EN
      .m0_lock(1'b0), .m1_lock(1'b0),
`endif
      .m0_gnt(gnt0_a[1]), .m1_gnt(gnt1_a[1]),
      .m0_rdata(rd0_a[1]), .m1_rdata(rd1_a[1]),
      .m0_rvalid(rv0_a[1]), .m1_rvalid(rv1_a[1]),
      .outbus_addr(oba_a[1]), .outbus_data(obd_a[1]), .outbus_we(obwe_a[1]),
      .inbus_addr(iba_a[1]), .inbus_re(ibre_a[1]), .inbus_data(ibd_a[1])
   );

   // Peripheral stub: answers a read strobe with memory contents one cycle later.
   always @(posedge clk) begin
      for (int l = 0; l < 2; l++) begin
         ibd_a[l] <= ibre_a[l] ? mem[iba_a[l]] : 8'h00;
      end
   end

   function automatic void chk(input int lane, input string nm,
                               input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL lane%0d %s cyc=%0d got=%h expected=%h", lane, nm, cyc, act, exp_v);
      end
   endfunction

   // Drive one cycle of stimulus and advance the reference model of both lanes.
   task automatic step(input bit rst,
                       input bit r0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                       input bit r1, input bit w1, input logic [7:0] a1, input logic [7:0] d1,
                       input bit l0, input bit l1);
      bus_t       eb;
      rd_t        er;
      int         win;
      bit         c0, c1, lk0, lk1, we;
      logic [7:0] a, d;
      @(posedge clk);
      #1;
      reset = rst;
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      m0_lock = l0; m1_lock = l1;
      for (int l = 0; l < 2; l++) begin
         lk0 = (l == 0) ? l0 : 1'b0;
         lk1 = (l == 0) ? l1 : 1'b0;
         if (!rst) begin
            exp_gnt[l] = 2'b00;
            last_m[l] = 1;
            lock_owner[l] = -1;
            // Reads whose return would land after this reset edge are lost.
            while (rq[l].size() > 0 && rq[l][rq[l].size()-1].due > cyc)
               void'(rq[l].pop_back());
         end else begin
            if (lock_owner[l] == 0 && !lk0) lock_owner[l] = -1;
            if (lock_owner[l] == 1 && !lk1) lock_owner[l] = -1;
            c0 = r0 && (lock_owner[l] != 1);
            c1 = r1 && (lock_owner[l] != 0);
            win = -1;
            if (c0 && c1) win = (l == 1) ? 0 : 1 - last_m[l];
            else if (c0) win = 0;
            else if (c1) win = 1;
            exp_gnt[l] = {win == 1, win == 0};
            if (win >= 0) begin
               last_m[l] = win;
`ifdef PERIPH_BUS_ARB_LOCK_EN
               lock_owner[l] = ((win == 0) ? lk0 : lk1) ? win : -1;
`endif
               we = (win == 1) ? w1 : w0;
               a  = (win == 1) ? a1 : a0;
               d  = (win == 1) ? d1 : d0;
               eb.due = cyc + 1;
               eb.we  = we;
               eb.oa  = we ? a : 8'h00;
               eb.od  = we ? d : 8'h00;
               eb.re  = !we;
               eb.ia  = we ? 8'h00 : a;
               bq[l].push_back(eb);
               if (!we) begin
                  er.due = cyc + 2;
                  er.own = win;
                  er.data = mem[a];
                  rq[l].push_back(er);
               end
            end
         end
      end
   endtask

   // Monitor: compare grants, bus strobes and read returns against the queues.
   always @(negedge clk) begin : mon
      bus_t       eb;
      rd_t        er;
      logic [8:0] e0, e1;
      if (mon_en) begin
         for (int l = 0; l < 2; l++) begin
            chk(l, "gnt", {30'd0, gnt1_a[l], gnt0_a[l]}, {30'd0, exp_gnt[l]});
            eb.due = 0; eb.we = 1'b0; eb.oa = 8'h00; eb.od = 8'h00; eb.re = 1'b0; eb.ia = 8'h00;
            if (bq[l].size() > 0 && bq[l][0].due == cyc) eb = bq[l].pop_front();
            chk(l, "outbus", {15'd0, obwe_a[l], oba_a[l], obd_a[l]}, {15'd0, eb.we, eb.oa, eb.od});
            chk(l, "inbus", {23'd0, ibre_a[l], iba_a[l]}, {23'd0, eb.re, eb.ia});
            e0 = 9'd0;
            e1 = 9'd0;
            if (rq[l].size() > 0 && rq[l][0].due == cyc) begin
               er = rq[l].pop_front();
               if (er.own == 0) e0 = {1'b1, er.data};
               else e1 = {1'b1, er.data};
            end
            chk(l, "m0_read", {23'd0, rv0_a[l], rd0_a[l]}, {23'd0, e0});
            chk(l, "m1_read", {23'd0, rv1_a[l], rd1_a[l]}, {23'd0, e1});
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h30] = 8'h7E;
      mem[8'h00] = 8'h02;
      mem[8'h01] = 8'h15;

      repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      mon_en = 1'b1;

      // m0 write 0x56 <- 0xA5, then idle.
      step(1'b1, 1'b1, 1'b1, 8'h56, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

      // m1 read of 0x30 returning 0x7E.
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

      // Both masters request writes for 6 cycles.
      for (int i = 0; i < 6; i++)
         step(1'b1, 1'b1, 1'b1, 8'(8'h10 + i), 8'($urandom), 1'b1, 1'b1, 8'(8'h20 + i), 8'($urandom), 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

      // Back-to-back reads: m0 from 0x00, m1 from 0x01.
      repeat (4) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

      // Read accepted, reset in the inbus_re cycle with both requesting, then a tie.
      step(1'b1, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'h31, 8'h44, 1'b1, 1'b1, 8'h32, 8'h55, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 8'h33, 8'h66, 1'b1, 1'b1, 8'h34, 8'h77, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

`ifdef PERIPH_BUS_ARB_LOCK_EN
      // m1 takes a locked write; m0 is shut out until m1 drops its lock.
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h40, 8'h11, 1'b0, 1'b1);
      repeat (4) step(1'b1, 1'b1, 1'b1, 8'h41, 8'h22, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 8'h41, 8'h22, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
`endif

      // Random traffic with occasional reset and lock requests.
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 49) != 0,
              $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 8'($urandom), 8'($urandom),
              $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 8'($urandom), 8'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

      repeat (4) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
         chk(l, "bus_queue_drained", bq[l].size(), 32'd0);
         chk(l, "read_queue_drained", rq[l].size(), 32'd0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
